// File: rtl/hit_judge_if.sv
// Bundle between the player-input/shifter side and the hit judge.
// master drives the bottom row, shift strobe and keys; slave returns pulses and game state.
interface hit_judge_if #(
    parameter int SCORE_W = 10
);
    logic               shift;
    logic [2:0]         bottom_lane;
    logic [3:0]         keys;
    logic               correct_input;
    logic               miss;
    logic               wrong;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic [7:0]         combo;
    logic               game_over;

    modport master (
        output shift, bottom_lane, keys,
        input  correct_input, miss, wrong, score, lives, combo, game_over
    );

    modport slave (
        input  shift, bottom_lane, keys,
        output correct_input, miss, wrong, score, lives, combo, game_over
    );
endinterface

// File: rtl/hit_judge.sv
// Judges the bottom tile row against lane key edges and keeps score, lives and game-over state.
// Optional COMBO_BONUS_EN: builds the combo counter and doubles hit points once the combo reaches COMBO_THRESH.
//
// state | meaning
// PLAY  | judging hits, wrong keys and misses
// OVER  | lives exhausted; outputs frozen until reset
module hit_judge #(
    parameter int SCORE_W      = 10,
    parameter int LIVES        = 3,
    parameter int COMBO_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    hit_judge_if.slave  bus
);
    typedef enum logic {PLAY, OVER} state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state;
    logic [3:0]         keys_q;
    logic               hit_flag;
    logic [SCORE_W-1:0] score_q;
    logic [2:0]         lives_q;
    logic               correct_q;
    logic               miss_q;
    logic               wrong_q;
    logic               over_q;

    logic [3:0]         key_edge;
    logic [3:0]         lane_mask;
    logic               tile;
    logic               hit;
    logic               wrong_c;
    logic               miss_c;
    logic [2:0]         loss;
    logic [2:0]         lives_next;
    logic               bonus;
    logic [1:0]         add;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    assign key_edge = bus.keys & ~keys_q;

    always_comb begin
        lane_mask = 4'b0000;
        case (bus.bottom_lane)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0010;
            3'd3:    lane_mask = 4'b0100;
            3'd4:    lane_mask = 4'b1000;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign tile    = (lane_mask != 4'b0000) && !hit_flag;
    assign hit     = tile && (key_edge == lane_mask);
    assign wrong_c = (key_edge != 4'b0000) && !hit;
    assign miss_c  = bus.shift && tile && !hit;

    // A wrong key and a miss in the same cycle each cost a life.
    assign loss       = {2'b00, wrong_c} + {2'b00, miss_c};
    assign lives_next = (lives_q > loss) ? (lives_q - loss) : 3'd0;

`ifdef COMBO_BONUS_EN
    logic [7:0] combo_q;

    assign bonus     = (combo_q >= 8'(COMBO_THRESH));
    assign bus.combo = combo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            combo_q <= 8'd0;
        end else if (state == PLAY) begin
            if (wrong_c || miss_c)
                combo_q <= 8'd0;
            else if (hit && combo_q != 8'hFF)
                combo_q <= combo_q + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^COMBO_THRESH;
    assign bonus      = 1'b0;
    assign bus.combo  = 8'd0;
`endif

    assign add        = bonus ? 2'd2 : 2'd1;
    assign score_sum  = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, add};
    assign score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            keys_q    <= 4'b1111;
            hit_flag  <= 1'b0;
            score_q   <= '0;
            lives_q   <= 3'(LIVES);
            correct_q <= 1'b0;
            miss_q    <= 1'b0;
            wrong_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            keys_q    <= bus.keys;
            correct_q <= 1'b0;
            miss_q    <= 1'b0;
            wrong_q   <= 1'b0;
            case (state)
                PLAY: begin
                    correct_q <= hit;
                    miss_q    <= miss_c;
                    wrong_q   <= wrong_c;
                    if (hit)
                        score_q <= score_next;
                    lives_q <= lives_next;
                    // A shift starts a new row, so it wins over a same-cycle hit.
                    if (bus.shift)
                        hit_flag <= 1'b0;
                    else if (hit)
                        hit_flag <= 1'b1;
                    if (lives_next == 3'd0) begin
                        state  <= OVER;
                        over_q <= 1'b1;
                    end
                end
                OVER: begin
                    over_q <= 1'b1;
                end
                default: begin
                    state <= OVER;
                end
            endcase
        end
    end

    assign bus.correct_input = correct_q;
    assign bus.miss          = miss_q;
    assign bus.wrong         = wrong_q;
    assign bus.score         = score_q;
    assign bus.lives         = lives_q;
    assign bus.game_over     = over_q;
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hits, misses, wrong keys, game over, reset and combo scoring.
module tb_hit_judge;
    localparam int SCORE_W = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    hit_judge_if #(.SCORE_W(SCORE_W)) bus ();

    hit_judge #(.SCORE_W(SCORE_W), .LIVES(3), .COMBO_THRESH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] lane, input logic [3:0] k, input logic sh);
        bus.bottom_lane = lane;
        bus.keys        = k;
        bus.shift       = sh;
    endtask

`ifdef COMBO_BONUS_EN
    localparam int COMBO_AFTER_T4 = 2;
    localparam int SCORE_T6       = 12;
    localparam int COMBO_T6       = 10;
`else
    localparam int COMBO_AFTER_T4 = 0;
    localparam int SCORE_T6       = 10;
    localparam int COMBO_T6       = 0;
`endif

    initial begin
        reset = 1'b1;
        drive(3'd0, 4'b0000, 1'b0);
        tick;
        tick;
        check("rst_score", 32'(bus.score), 0);
        check("rst_lives", 32'(bus.lives), 3);
        check("rst_combo", 32'(bus.combo), 0);
        check("rst_over", 32'(bus.game_over), 0);
        check("rst_pulses", 32'({bus.correct_input, bus.miss, bus.wrong}), 0);
        reset = 1'b0;
        tick;

        // 1: hit on lane 2
        drive(3'd2, 4'b0010, 1'b0);
        tick;
        check("t1_correct", 32'(bus.correct_input), 1);
        check("t1_score", 32'(bus.score), 1);
        check("t1_lives", 32'(bus.lives), 3);
        check("t1_wrong", 32'(bus.wrong), 0);
        tick;
        check("t1_pulse_len", 32'(bus.correct_input), 0);
        drive(3'd2, 4'b0000, 1'b0);
        tick;
        drive(3'd2, 4'b0000, 1'b1);
        tick;
        check("t1_hit_row_no_miss", 32'(bus.miss), 0);
        check("t1_lives_kept", 32'(bus.lives), 3);

        // 2: unhit tile shifted out
        drive(3'd3, 4'b0000, 1'b1);
        tick;
        check("t2_miss", 32'(bus.miss), 1);
        check("t2_lives", 32'(bus.lives), 2);
        check("t2_score", 32'(bus.score), 1);
        check("t2_combo", 32'(bus.combo), 0);
        drive(3'd3, 4'b0000, 1'b0);
        tick;
        check("t2_pulse_len", 32'(bus.miss), 0);

        // 3: mismatched lane
        drive(3'd1, 4'b0100, 1'b0);
        tick;
        check("t3_wrong", 32'(bus.wrong), 1);
        check("t3_correct", 32'(bus.correct_input), 0);
        check("t3_lives", 32'(bus.lives), 1);
        check("t3_combo", 32'(bus.combo), 0);
        drive(3'd1, 4'b0000, 1'b0);
        tick;

        // 4: key rise and shift together on lane 4
        drive(3'd4, 4'b1000, 1'b1);
        tick;
        check("t4_correct", 32'(bus.correct_input), 1);
        check("t4_miss", 32'(bus.miss), 0);
        check("t4_score", 32'(bus.score), 2);
        drive(3'd4, 4'b0000, 1'b0);
        tick;
        drive(3'd4, 4'b1000, 1'b0);
        tick;
        check("t4_flag_cleared_hit", 32'(bus.correct_input), 1);
        check("t4_score2", 32'(bus.score), 3);
        check("t4_combo", 32'(bus.combo), COMBO_AFTER_T4);
        drive(3'd0, 4'b0000, 1'b1);
        tick;
        check("t4_empty_shift", 32'(bus.miss), 0);

        // wrong and miss together with one life left: floor at 0
        drive(3'd2, 4'b0001, 1'b1);
        tick;
        check("wm_wrong", 32'(bus.wrong), 1);
        check("wm_miss", 32'(bus.miss), 1);
        check("wm_lives", 32'(bus.lives), 0);
        check("wm_over", 32'(bus.game_over), 1);
        drive(3'd3, 4'b0000, 1'b0);
        tick;
        drive(3'd3, 4'b0100, 1'b0);
        tick;
        check("over_no_pulse", 32'({bus.correct_input, bus.miss, bus.wrong}), 0);
        check("over_score", 32'(bus.score), 3);

        // 5: three misses
        reset = 1'b1;
        drive(3'd0, 4'b0000, 1'b0);
        tick;
        reset = 1'b0;
        tick;
        check("t5_lives0", 32'(bus.lives), 3);
        check("t5_over0", 32'(bus.game_over), 0);
        drive(3'd1, 4'b0000, 1'b1);
        tick;
        check("t5_miss1", 32'({bus.miss, bus.lives}), {1'b1, 3'd2});
        tick;
        check("t5_miss2", 32'({bus.miss, bus.lives}), {1'b1, 3'd1});
        tick;
        check("t5_miss3", 32'({bus.miss, bus.lives}), {1'b1, 3'd0});
        check("t5_over", 32'(bus.game_over), 1);
        drive(3'd1, 4'b0000, 1'b0);
        tick;
        check("t5_no_miss", 32'(bus.miss), 0);
        drive(3'd1, 4'b0001, 1'b0);
        tick;
        check("t5_frozen", 32'({bus.correct_input, bus.wrong, bus.lives}), 0);
        reset = 1'b1;
        drive(3'd0, 4'b0000, 1'b0);
        tick;
        reset = 1'b0;
        tick;
        check("t5_rst_lives", 32'(bus.lives), 3);
        check("t5_rst_over", 32'(bus.game_over), 0);
        check("t5_rst_score", 32'(bus.score), 0);

        // 6: ten consecutive hits
        for (int i = 0; i < 10; i++) begin
            drive(3'd1, 4'b0001, 1'b1);
            tick;
            check("t6_hit", 32'(bus.correct_input), 1);
            drive(3'd0, 4'b0000, 1'b0);
            tick;
        end
        check("t6_score", 32'(bus.score), SCORE_T6);
        check("t6_combo", 32'(bus.combo), COMBO_T6);
        check("t6_lives", 32'(bus.lives), 3);
        drive(3'd0, 4'b0010, 1'b0);
        tick;
        check("t6_empty_wrong", 32'(bus.wrong), 1);
        check("t6_combo_clr", 32'(bus.combo), 0);
        check("t6_lives2", 32'(bus.lives), 2);
        drive(3'd0, 4'b0000, 1'b0);
        tick;

        // reset drops an in-flight hit; keys held through reset give no edge
        drive(3'd1, 4'b0001, 1'b0);
        reset = 1'b1;
        tick;
        check("rst_drop_pulse", 32'(bus.correct_input), 0);
        check("rst_mid_score", 32'(bus.score), 0);
        check("rst_mid_lives", 32'(bus.lives), 3);
        reset = 1'b0;
        tick;
        check("rst_held_keys", 32'({bus.correct_input, bus.wrong}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
